// File: rtl/apb_arb_pkg.sv
// Shared definitions for APB request arbitration: FSM states and slot decode.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int SLOT_MSB = 27;
    localparam int SLOT_LSB = 24;
    localparam int NSLOTS   = 16;

    // One-hot APB slot select taken from the slot field of an address.
    function automatic logic [NSLOTS-1:0] slot_sel(input logic [31:0] addr);
        logic [NSLOTS-1:0] sel;
        sel = '0;
        sel[addr[SLOT_MSB:SLOT_LSB]] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Request-port and APB bundle between the requesters, the arbiter and the slot fabric.
// Latency: n/a (wires only).
// Backpressure: requesters hold REQ until DONE; the APB side stalls through PREADY.
interface apb_req_arbiter_if #(
    parameter int NREQ = 4
);
    import apb_arb_pkg::NSLOTS;

    // requester side
    logic [NREQ-1:0]    REQ;
    logic [NREQ-1:0]    REQ_WRITE;
    logic [NREQ*32-1:0] REQ_ADDR;
    logic [NREQ*32-1:0] REQ_WDATA;
    logic [NREQ-1:0]    DONE;
    logic [31:0]        RSP_RDATA;
    logic               RSP_ERR;
    logic               BUSY;
    logic [2:0]         OWNER;

    // APB side
    logic [31:0]        PADDR;
    logic               PWRITE;
    logic [31:0]        PWDATA;
    logic [NSLOTS-1:0]  PSEL;
    logic               PENABLE;
    logic [31:0]        PRDATA;
    logic               PREADY;
    logic               PSLVERR;

    // arbiter view
    modport master (
        input  REQ, REQ_WRITE, REQ_ADDR, REQ_WDATA,
        output DONE, RSP_RDATA, RSP_ERR, BUSY, OWNER,
        output PADDR, PWRITE, PWDATA, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    // environment view: requesters plus APB slave
    modport slave (
        output REQ, REQ_WRITE, REQ_ADDR, REQ_WDATA,
        input  DONE, RSP_RDATA, RSP_ERR, BUSY, OWNER,
        input  PADDR, PWRITE, PWDATA, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational one-hot round-robin pick; search starts just above last_i and wraps.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [2:0]      last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [2:0]      idx_o,
    output logic            vld_o
);

    // First pass covers indices above last_i, second pass wraps to the rest.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!vld_o && req_i[i] && (i > int'(last_i))) begin
                gnt_o[i] = 1'b1;
                idx_o    = 3'(i);
                vld_o    = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!vld_o && req_i[i] && (i <= int'(last_i))) begin
                gnt_o[i] = 1'b1;
                idx_o    = 3'(i);
                vld_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter and APB3 sequencer sharing one APB bus among NREQ request ports.
// Latency: grant edge -> SETUP -> ACCESS -> DONE, 4 cycles minimum per transfer.
// Backpressure: PREADY low stretches ACCESS, bounded by TIMEOUT (0 = unbounded).
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               PCLK,
    input  logic               PRESET,
    apb_req_arbiter_if.master  arb_io
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e           state_q, state_d;
    logic [2:0]       owner_q, owner_d;
    logic [31:0]      addr_q,  addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             write_q, write_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q,   err_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [2:0]       arb_idx;
    logic             arb_vld;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i  (arb_io.REQ),
        .last_i (owner_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .vld_o  (arb_vld)
    );

    // Next-state: grant latch in IDLE, wait/timeout handling in ACCESS.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    owner_d = arb_idx;
                    for (int i = 0; i < NREQ; i++) begin
                        if (arb_gnt[i]) begin
                            addr_d  = arb_io.REQ_ADDR[32*i +: 32];
                            wdata_d = arb_io.REQ_WDATA[32*i +: 32];
                            write_d = arb_io.REQ_WRITE[i];
                        end
                    end
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (arb_io.PREADY) begin
                    // write responses never carry read data
                    rdata_d = write_q ? 32'h0 : arb_io.PRDATA;
                    err_d   = arb_io.PSLVERR;
                    state_d = DONE;
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    // this is the TIMEOUT-th stalled ACCESS cycle: force completion
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // REQ deliberately ignored here so the owner can drop or re-arm
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transfer and rearms requester 0 as first winner.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            owner_q <= 3'(NREQ - 1);
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Completion pulse goes only to the current owner.
    always_comb begin
        arb_io.DONE = '0;
        for (int i = 0; i < NREQ; i++) begin
            arb_io.DONE[i] = (state_q == DONE) && (owner_q == 3'(i));
        end
    end

    // PSEL/PENABLE qualify the bus; address and data simply hold between transfers.
    assign arb_io.PSEL      = ((state_q == SETUP) || (state_q == ACCESS)) ? slot_sel(addr_q) : '0;
    assign arb_io.PENABLE   = (state_q == ACCESS);
    assign arb_io.PADDR     = addr_q;
    assign arb_io.PWDATA    = wdata_q;
    assign arb_io.PWRITE    = write_q;
    assign arb_io.BUSY      = (state_q != IDLE);
    assign arb_io.OWNER     = owner_q;
    assign arb_io.RSP_RDATA = rdata_q;
    assign arb_io.RSP_ERR   = err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: table of single transfers plus
// contention and reset-abort sequences. Inputs change and outputs are sampled
// on the falling edge of PCLK.
module tb_apb_req_arbiter;

    localparam int NREQ = 4;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b1;

    apb_req_arbiter_if #(.NREQ(NREQ)) arb ();

    apb_req_arbiter #(.NREQ(NREQ), .TIMEOUT(8)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .arb_io (arb)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int          idx;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        slverr;
        int          nwait;      // PREADY-low ACCESS cycles before PREADY=1
        logic [15:0] exp_psel;
        int          exp_done;   // cycle of DONE counted from the grant edge
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic pulse_reset();
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    // One transfer from a single requester; REQ and its fields are disturbed
    // right after the grant to show the latched copies do not follow them.
    task automatic run_vec(input int vi);
        vec_t             v;
        int               acc;
        int               done_cyc;
        logic             stable;
        logic [NREQ-1:0]  done_v;
        logic [31:0]      rd;
        logic             er;
        v        = vecs[vi];
        acc      = 0;
        done_cyc = -1;
        stable   = 1'b1;
        done_v   = '0;
        rd       = '0;
        er       = 1'b0;
        arb.REQ_WRITE[v.idx]          = v.wr;
        arb.REQ_ADDR[32*v.idx +: 32]  = v.addr;
        arb.REQ_WDATA[32*v.idx +: 32] = v.wdata;
        arb.PRDATA  = v.prdata;
        arb.PREADY  = 1'b0;
        arb.PSLVERR = 1'b0;
        arb.REQ[v.idx] = 1'b1;
        for (int c = 1; c <= 30 && done_cyc < 0; c++) begin
            @(negedge PCLK);
            if (c == 1) begin
                check($sformatf("v%0d setup_psel", vi), 32'(arb.PSEL), 32'(v.exp_psel));
                check($sformatf("v%0d setup_penable", vi), 32'(arb.PENABLE), 32'd0);
                check($sformatf("v%0d paddr", vi), arb.PADDR, v.addr);
                check($sformatf("v%0d pwrite", vi), 32'(arb.PWRITE), 32'(v.wr));
                arb.REQ[v.idx]                = 1'b0;
                arb.REQ_ADDR[32*v.idx +: 32]  = ~v.addr;
                arb.REQ_WDATA[32*v.idx +: 32] = ~v.wdata;
                arb.REQ_WRITE[v.idx]          = ~v.wr;
            end
            if (arb.PENABLE) begin
                if (arb.PSEL !== v.exp_psel || arb.PADDR !== v.addr ||
                    (v.wr && arb.PWDATA !== v.wdata)) stable = 1'b0;
                arb.PREADY  = (acc >= v.nwait);
                arb.PSLVERR = (acc >= v.nwait) ? v.slverr : 1'b0;
                acc++;
            end else begin
                arb.PREADY  = 1'b0;
                arb.PSLVERR = 1'b0;
            end
            if (arb.DONE != '0) begin
                done_cyc = c;
                done_v   = arb.DONE;
                rd       = arb.RSP_RDATA;
                er       = arb.RSP_ERR;
                check($sformatf("v%0d done_psel", vi), 32'(arb.PSEL), 32'd0);
                check($sformatf("v%0d done_penable", vi), 32'(arb.PENABLE), 32'd0);
            end
        end
        arb.PREADY  = 1'b0;
        arb.PSLVERR = 1'b0;
        check($sformatf("v%0d access_stable", vi), 32'(stable), 32'd1);
        check($sformatf("v%0d done_cycle", vi), 32'(done_cyc), 32'(v.exp_done));
        check($sformatf("v%0d done_vec", vi), 32'(done_v), 32'(1 << v.idx));
        check($sformatf("v%0d rsp_rdata", vi), rd, v.exp_rdata);
        check($sformatf("v%0d rsp_err", vi), 32'(er), 32'(v.exp_err));
        check($sformatf("v%0d owner", vi), 32'(arb.OWNER), 32'(v.idx));
        @(negedge PCLK);
        check($sformatf("v%0d idle_busy", vi), 32'(arb.BUSY), 32'd0);
    endtask

    int exp_ord[5];
    int got_ord[5];
    int got_cyc[5];
    int got;

    initial begin
        //           idx wr    addr           wdata          prdata         slverr nwait psel     done rdata          err
        vecs[0] = '{1, 1'b0, 32'h0200_0010, 32'h0000_0000, 32'hA5A5_0001, 1'b0, 0,  16'h0004, 3,  32'hA5A5_0001, 1'b0};
        vecs[1] = '{0, 1'b1, 32'h0F00_0000, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 5,  16'h8000, 8,  32'h0000_0000, 1'b0};
        vecs[2] = '{3, 1'b0, 32'h0500_0004, 32'h0000_0000, 32'h0BAD_F00D, 1'b1, 0,  16'h0020, 3,  32'h0BAD_F00D, 1'b1};
        vecs[3] = '{2, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'h0000_1234, 1'b0, 2,  16'h0001, 5,  32'h0000_1234, 1'b0};
        vecs[4] = '{1, 1'b0, 32'h0A00_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 20, 16'h0400, 10, 32'h0000_0000, 1'b1};
        vecs[5] = '{2, 1'b1, 32'h0300_0000, 32'h5555_AAAA, 32'hCAFE_F00D, 1'b1, 1,  16'h0008, 4,  32'h0000_0000, 1'b1};

        arb.REQ       = '0;
        arb.REQ_WRITE = '0;
        arb.REQ_ADDR  = '0;
        arb.REQ_WDATA = '0;
        arb.PRDATA    = '0;
        arb.PREADY    = 1'b0;
        arb.PSLVERR   = 1'b0;

        // reset state
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        check("rst_psel", 32'(arb.PSEL), 32'd0);
        check("rst_penable", 32'(arb.PENABLE), 32'd0);
        check("rst_done", 32'(arb.DONE), 32'd0);
        check("rst_busy", 32'(arb.BUSY), 32'd0);
        check("rst_owner", 32'(arb.OWNER), 32'd3);
        check("rst_paddr", arb.PADDR, 32'd0);
        check("rst_pwdata", arb.PWDATA, 32'd0);
        check("rst_pwrite", 32'(arb.PWRITE), 32'd0);
        check("rst_rdata", arb.RSP_RDATA, 32'd0);
        check("rst_err", 32'(arb.RSP_ERR), 32'd0);

        // single-transfer table
        for (int i = 0; i < 6; i++) run_vec(i);

        // contention: all four held high, rotation 0,1,2,3,0 four cycles apart
        pulse_reset();
        exp_ord = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) begin
            arb.REQ_ADDR[32*i +: 32] = 32'(i) << 24;
        end
        arb.REQ_WRITE = '0;
        arb.PREADY    = 1'b1;
        arb.REQ       = '1;
        got = 0;
        for (int c = 1; c <= 60 && got < 5; c++) begin
            @(negedge PCLK);
            if (arb.DONE != '0) begin
                got_ord[got] = onehot_idx(arb.DONE);
                got_cyc[got] = c;
                got++;
                if (got == 5) arb.REQ = '0;
            end
        end
        arb.REQ = '0;
        check("cont_count", 32'(got), 32'd5);
        for (int j = 0; j < got; j++) begin
            check($sformatf("cont_order%0d", j), 32'(got_ord[j]), 32'(exp_ord[j]));
        end
        for (int j = 1; j < got; j++) begin
            check($sformatf("cont_spacing%0d", j), 32'(got_cyc[j] - got_cyc[j-1]), 32'd4);
        end

        // reset in the middle of ACCESS for requester 2
        @(negedge PCLK);
        arb.PREADY = 1'b0;
        arb.REQ_ADDR[32*2 +: 32] = 32'h0200_0000;
        arb.REQ[2] = 1'b1;
        for (int c = 0; c < 10 && !arb.PENABLE; c++) @(negedge PCLK);
        check("abort_reach_access", 32'(arb.PENABLE), 32'd1);
        check("abort_owner_before", 32'(arb.OWNER), 32'd2);
        PRESET = 1'b1;
        arb.REQ[0] = 1'b1;
        arb.REQ[1] = 1'b1;
        arb.PREADY = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        check("abort_psel", 32'(arb.PSEL), 32'd0);
        check("abort_penable", 32'(arb.PENABLE), 32'd0);
        check("abort_done", 32'(arb.DONE), 32'd0);
        check("abort_busy", 32'(arb.BUSY), 32'd0);
        check("abort_owner", 32'(arb.OWNER), 32'd3);
        check("abort_paddr", arb.PADDR, 32'd0);
        got = 0;
        for (int c = 1; c <= 40 && got < 3; c++) begin
            @(negedge PCLK);
            if (arb.DONE != '0) begin
                got_ord[got] = onehot_idx(arb.DONE);
                if (got_ord[got] >= 0) arb.REQ[got_ord[got]] = 1'b0;
                got++;
            end
        end
        check("after_abort_count", 32'(got), 32'd3);
        for (int j = 0; j < got; j++) begin
            check($sformatf("after_abort_order%0d", j), 32'(got_ord[j]), 32'(j));
        end
        @(negedge PCLK);
        check("final_busy", 32'(arb.BUSY), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
